squeeze_dump_unit: RTL and testbench
====================================

// Module: squeeze_dump_unit
// PURPOSE
// Parametrised Keccak squeeze/dump stage. It takes rate blocks from the permute stage and streams them out
// as OUT_W-bit words on a valid/ready interface, stopping after the programmed output length.
// For XOF modes it issues a permutation request for each further block; the last word is byte-masked.
// Supports SHAKE128, SHAKE256, SHA3-256 and SHA3-512. Sits between the permute datapath and the output port.
// PARAMETERS
// OUT_W     64    output word width in bits; multiple of 8 that divides 576, 1088 and 1344
// RATE_MAX  1344  widest rate in bits (SHAKE128)
// LEN_W     32    width of the output length field (bits)
// PORTS
// clk        in   1          clock
// rst        in   1          synchronous reset, active-high
// start      in   1          begin job; sampled only in IDLE
// mode_in    in   2          00 SHAKE128 (168 B), 01 SHAKE256 (136 B), 10 SHA3-256 (136 B), 11 SHA3-512 (72 B)
// len_in     in   LEN_W      output length in bits; bits[2:0] ignored; used only in SHAKE modes
// abort      in   1          synchronous job cancel
// blk_valid  in   1          rate block available from permute stage
// blk_ready  out  1          unit accepts a block this cycle
// rate_in    in   RATE_MAX   rate block; first stream byte at [RATE_MAX-1 -: 8]; shorter rates MSB-aligned
// perm_req   out  1          1-cycle pulse: the permute stage must produce the next block
// dout       out  OUT_W      output word; first byte at MSB; invalid bytes forced to 0
// dout_keep  out  OUT_W/8    byte-valid mask; bit OUT_W/8-1 = MSB byte
// dout_last  out  1          final word of job
// dout_valid out  1          word valid
// dout_ready in   1          sink accepts word
// done       out  1          1-cycle pulse at job end
// busy       out  1          state != IDLE
// BEHAVIOUR
// - WB = OUT_W/8. bytes_left (LEN_W-3 bits) = len_in>>3 for SHAKE; 32 for SHA3-256; 64 for SHA3-512.
// - Reset and abort: state=IDLE; bytes_left=0; buffer=0; every output 0. abort overrides all other inputs.
// - FSM states: IDLE, WAIT_BLK, DRAIN, DONE.
// - IDLE --start--> WAIT_BLK if bytes_left!=0; otherwise DONE. mode and length are latched on this cycle.
// - WAIT_BLK: blk_ready=1. On blk_valid, load the PISO buffer with rate_in.
//   words_blk = min(rate_bytes/WB, ceil(bytes_left/WB)). Go to DRAIN.
// - dout_valid rises the cycle after the block handshake (1-cycle latency).
// - DRAIN: dout_valid=1; dout = buffer[RATE_MAX-1 -: OUT_W].
//   dout, keep and last hold stable while dout_ready=0.
//   On dout_ready: shift left by OUT_W, bytes_left -= min(WB,bytes_left), word_cnt decrements.
// - dout_keep = all ones when bytes_left>=WB; otherwise the top bytes_left bits are set. dout bytes with keep=0 read 0.
// - dout_last = 1 when bytes_left<=WB.
// - End of block in DRAIN (word_cnt==1 accepted):
//   - bytes_left becomes 0: go to DONE.
//   - bytes_left nonzero: pulse perm_req for 1 cycle and go to WAIT_BLK.
// - Rate-boundary word with bytes_left exactly WB: dout_last=1 and no perm_req.
// - DONE: done=1 for one cycle, then IDLE. start is ignored outside IDLE; blk_valid is ignored outside WAIT_BLK.
// - SHA3 modes never raise perm_req, because the digest fits in one block.
// - bytes_left saturates at 0 and never wraps.
// TESTING
// - SHAKE128, len=256, OUT_W=64 -> 4 words, keep=8'hFF each, last on word 4, done, perm_req never asserted.
// - SHAKE256, len=1096 (137 B): 17 full words -> perm_req pulse.
//   Second block -> 1 word with keep=8'h80, low 7 bytes 0, last=1.
// - dout_ready low for 5 cycles mid-drain -> dout, keep and last unchanged; no word lost or duplicated.
// - start with len=0 in SHAKE128 -> done 1 cycle later; blk_ready never asserted.
// - SHA3-512 with len_in=0xFFFF -> exactly 8 words, last on 8th, no perm_req.
// - abort during word 3 of a SHAKE128 job -> next cycle: IDLE, dout_valid=0, busy=0.
//   A following job runs correctly.

Source files
------------

// File: rtl/squeeze_dump_unit.sv
// Keccak squeeze/dump stage: buffers one rate block and streams it out as OUT_W-bit words.
// It requests further permutations for long XOF outputs and byte-masks the final word.
module squeeze_dump_unit #(
    parameter int OUT_W    = 64,
    parameter int RATE_MAX = 1344,
    parameter int LEN_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode_in,
    input  logic [LEN_W-1:0]      len_in,
    input  logic                  abort,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [RATE_MAX-1:0]   rate_in,
    output logic                  perm_req,
    output logic [OUT_W-1:0]      dout,
    output logic [OUT_W/8-1:0]    dout_keep,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  done,
    output logic                  busy
);

    localparam int WB  = OUT_W / 8;
    localparam int NB  = LEN_W - 3;
    localparam int WCW = $clog2(RATE_MAX / OUT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state, w_state_next;
    logic [NB-1:0]       r_bytes_left, w_bytes_left_next;
    logic [1:0]          r_mode, w_mode_next;
    logic [RATE_MAX-1:0] r_buf, w_buf_next;
    logic [WCW-1:0]      r_word_cnt, w_word_cnt_next;
    logic                r_perm_req, w_perm_req_next;

    logic [NB-1:0]       w_start_bytes;
    logic [NB-1:0]       w_dec;
    logic [NB-1:0]       w_bytes_after;
    logic [NB:0]         w_ceil_words;
    logic [NB:0]         w_rate_words;
    logic [WCW-1:0]      w_words_blk;
    logic                w_drain;
    logic [WB-1:0]       w_keep;

    // Only the SHAKE modes take their length from len_in; SHA3 digests are fixed.
    always_comb begin
        w_start_bytes = '0;
        case (mode_in)
            2'b00, 2'b01: w_start_bytes = len_in[LEN_W-1:3];
            2'b10:        w_start_bytes = NB'(32);
            default:      w_start_bytes = NB'(64);
        endcase
    end

    always_comb begin
        w_rate_words = '0;
        case (r_mode)
            2'b00:        w_rate_words = (NB+1)'(168 / WB);
            2'b01, 2'b10: w_rate_words = (NB+1)'(136 / WB);
            default:      w_rate_words = (NB+1)'(72 / WB);
        endcase
    end

    assign w_ceil_words  = ({1'b0, r_bytes_left} + (NB+1)'(WB - 1)) / (NB+1)'(WB);
    assign w_words_blk   = (w_ceil_words < w_rate_words) ? WCW'(w_ceil_words) : WCW'(w_rate_words);
    assign w_dec         = (r_bytes_left >= NB'(WB)) ? NB'(WB) : r_bytes_left;
    assign w_bytes_after = r_bytes_left - w_dec;

    always_comb begin
        w_state_next      = r_state;
        w_bytes_left_next = r_bytes_left;
        w_mode_next       = r_mode;
        w_buf_next        = r_buf;
        w_word_cnt_next   = r_word_cnt;
        w_perm_req_next   = 1'b0;
        if (abort) begin
            w_state_next      = S_IDLE;
            w_bytes_left_next = '0;
            w_mode_next       = '0;
            w_buf_next        = '0;
            w_word_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_mode_next       = mode_in;
                        w_bytes_left_next = w_start_bytes;
                        w_state_next      = (w_start_bytes != '0) ? S_WAIT_BLK : S_DONE;
                    end
                end
                S_WAIT_BLK: begin
                    if (blk_valid) begin
                        w_buf_next      = rate_in;
                        w_word_cnt_next = w_words_blk;
                        w_state_next    = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dout_ready) begin
                        w_buf_next        = r_buf << OUT_W;
                        w_bytes_left_next = w_bytes_after;
                        w_word_cnt_next   = r_word_cnt - WCW'(1);
                        if (w_bytes_after == '0) begin
                            w_state_next = S_DONE;
                        end else if (r_word_cnt == WCW'(1)) begin
                            // Block exhausted but output still owed: fetch another permutation.
                            w_perm_req_next = 1'b1;
                            w_state_next    = S_WAIT_BLK;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bytes_left <= '0;
            r_mode       <= '0;
            r_buf        <= '0;
            r_word_cnt   <= '0;
            r_perm_req   <= 1'b0;
        end else begin
            r_bytes_left <= w_bytes_left_next;
            r_mode       <= w_mode_next;
            r_buf        <= w_buf_next;
            r_word_cnt   <= w_word_cnt_next;
            r_perm_req   <= w_perm_req_next;
        end
    end

    assign w_drain = (r_state == S_DRAIN);

    // Keep bit gi covers byte (WB-1-gi) counted from the MSB end of the word.
    genvar gi;
    generate
        for (gi = 0; gi < WB; gi++) begin : g_byte
            assign w_keep[gi] = w_drain && (r_bytes_left > NB'(WB - 1 - gi));
            assign dout[gi*8 +: 8] = w_keep[gi] ? r_buf[RATE_MAX-OUT_W + gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign dout_keep  = w_keep;
    assign dout_last  = w_drain && (r_bytes_left <= NB'(WB));
    assign dout_valid = w_drain;
    assign blk_ready  = (r_state == S_WAIT_BLK);
    assign perm_req   = r_perm_req;
    assign done       = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_squeeze_dump_unit.sv
// Scoreboard bench for squeeze_dump_unit: stimulus queues expected words, a forked monitor
// pops and compares each accepted output word.
module tb_squeeze_dump_unit;

    localparam int OUT_W    = 64;
    localparam int RATE_MAX = 1344;
    localparam int LEN_W    = 32;
    localparam int WB       = OUT_W / 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [1:0]          mode_in;
    logic [LEN_W-1:0]    len_in;
    logic                abort;
    logic                blk_valid;
    logic                blk_ready;
    logic [RATE_MAX-1:0] rate_in;
    logic                perm_req;
    logic [OUT_W-1:0]    dout;
    logic [WB-1:0]       dout_keep;
    logic                dout_last;
    logic                dout_valid;
    logic                dout_ready;
    logic                done;
    logic                busy;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [WB-1:0]    keep;
        logic             last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   perm_cnt = 0;
    int   done_cnt = 0;
    int   blk_ready_cnt = 0;
    int   acc_cnt = 0;

    squeeze_dump_unit #(.OUT_W(OUT_W), .RATE_MAX(RATE_MAX), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_in    (mode_in),
        .len_in     (len_in),
        .abort      (abort),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .rate_in    (rate_in),
        .perm_req   (perm_req),
        .dout       (dout),
        .dout_keep  (dout_keep),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int seed, input int k);
        return 8'((seed * 37 + k * 13 + 1) & 255);
    endfunction

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_block(input int seed, input int nbytes, input bit final_blk);
        int nw;
        nw = (nbytes + WB - 1) / WB;
        for (int w = 0; w < nw; w++) begin
            exp_t e;
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < WB; j++) begin
                if (w * WB + j < nbytes) begin
                    e.data[OUT_W-1-8*j -: 8] = pat(seed, w * WB + j);
                    e.keep[WB-1-j] = 1'b1;
                end
            end
            e.last = final_blk && (w == nw - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic start_job(input logic [1:0] m, input logic [LEN_W-1:0] len);
        mode_in = m;
        len_in  = len;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic give_block(input int seed);
        for (int i = 0; i < 300 && !blk_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!blk_ready) begin
            checks++;
            errors++;
            $display("FAIL blk_ready_timeout: got 0, expected 1 (seed %0d)", seed);
        end else begin
            for (int k = 0; k < RATE_MAX / 8; k++) begin
                rate_in[RATE_MAX-1-8*k -: 8] = pat(seed, k);
            end
            blk_valid = 1'b1;
            @(posedge clk); #1;
            blk_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int base);
        for (int i = 0; i < 400 && done_cnt == base; i++) begin
            @(posedge clk); #1;
        end
        chk(name, 64'(done_cnt - base), 64'd1);
    endtask

    task automatic wait_acc(input int target);
        for (int i = 0; i < 300 && acc_cnt < target; i++) begin
            @(posedge clk); #1;
        end
        chk("accepted_words", 64'(acc_cnt >= target), 64'd1);
    endtask

    initial begin
        int base_done, base_perm, base_blk;
        rst        = 1'b1;
        start      = 1'b0;
        mode_in    = 2'b00;
        len_in     = '0;
        abort      = 1'b0;
        blk_valid  = 1'b0;
        rate_in    = '0;
        dout_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (perm_req)  perm_cnt++;
                    if (done)      done_cnt++;
                    if (blk_ready) blk_ready_cnt++;
                    if (dout_valid && dout_ready) begin
                        acc_cnt++;
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_word: got %h keep %h last %b, expected none",
                                     dout, dout_keep, dout_last);
                        end else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            if (dout !== e.data || dout_keep !== e.keep || dout_last !== e.last) begin
                                errors++;
                                $display("FAIL word_%0d: got %h keep %h last %b, expected %h keep %h last %b",
                                         acc_cnt, dout, dout_keep, dout_last, e.data, e.keep, e.last);
                            end else begin
                                $display("word %0d: data %h keep %h last %b ok",
                                         acc_cnt, dout, dout_keep, dout_last);
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(dout_valid), 64'd0);
        chk("reset_blk_ready", 64'(blk_ready), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_perm_req", 64'(perm_req), 64'd0);
        chk("reset_dout", dout, 64'd0);

        // SHAKE128, 256 bits: four full words from a single block.
        base_done = done_cnt; base_perm = perm_cnt;
        push_block(1, 32, 1'b1);
        start_job(2'b00, 32'd256);
        give_block(1);
        wait_done("shake128_256_done", base_done);
        chk("shake128_256_perm", 64'(perm_cnt - base_perm), 64'd0);
        chk("shake128_256_queue", 64'(sb_q.size()), 64'd0);

        // SHAKE256, 137 bytes: 17 words, one permutation request, then a 1-byte tail.
        base_done = done_cnt; base_perm = perm_cnt;
        push_block(2, 136, 1'b0);
        push_block(3, 1, 1'b1);
        start_job(2'b01, 32'd1096);
        give_block(2);
        give_block(3);
        wait_done("shake256_1096_done", base_done);
        chk("shake256_1096_perm", 64'(perm_cnt - base_perm), 64'd1);
        chk("shake256_1096_queue", 64'(sb_q.size()), 64'd0);

        // SHAKE128, 64 bytes, sink stalls for 5 cycles while word 4 is presented.
        base_done = done_cnt; base_perm = perm_cnt;
        push_block(4, 64, 1'b1);
        acc_cnt = 0;
        start_job(2'b00, 32'd512);
        give_block(4);
        wait_acc(3);
        dout_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 64'(dout_valid), 64'd1);
            chk("stall_dout", dout, sb_q[0].data);
            chk("stall_keep", 64'(dout_keep), 64'(sb_q[0].keep));
            chk("stall_last", 64'(dout_last), 64'(sb_q[0].last));
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        wait_done("stall_done", base_done);
        chk("stall_queue", 64'(sb_q.size()), 64'd0);
        chk("stall_perm", 64'(perm_cnt - base_perm), 64'd0);

        // SHAKE128 with zero length: straight to done, never asks for a block.
        base_done = done_cnt; base_blk = blk_ready_cnt;
        start_job(2'b00, 32'd0);
        chk("len0_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        chk("len0_idle", 64'(busy), 64'd0);
        chk("len0_blk_ready", 64'(blk_ready_cnt - base_blk), 64'd0);

        // SHA3-512 ignores len_in: exactly 64 bytes.
        base_done = done_cnt; base_perm = perm_cnt;
        push_block(5, 64, 1'b1);
        start_job(2'b11, 32'h0000_FFFF);
        give_block(5);
        wait_done("sha3_512_done", base_done);
        chk("sha3_512_perm", 64'(perm_cnt - base_perm), 64'd0);
        chk("sha3_512_queue", 64'(sb_q.size()), 64'd0);

        // Abort while word 3 of a SHAKE128 job is presented.
        base_done = done_cnt; base_perm = perm_cnt;
        push_block(6, 128, 1'b1);
        acc_cnt = 0;
        start_job(2'b00, 32'd1024);
        give_block(6);
        wait_acc(2);
        dout_ready = 1'b0;
        abort      = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", 64'(dout_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_keep", 64'(dout_keep), 64'd0);
        sb_q.delete();
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - base_done), 64'd0);
        chk("abort_no_perm", 64'(perm_cnt - base_perm), 64'd0);

        // SHA3-256 after the abort: 32 bytes, four words.
        base_done = done_cnt; base_perm = perm_cnt;
        push_block(7, 32, 1'b1);
        start_job(2'b10, 32'd0);
        give_block(7);
        wait_done("sha3_256_done", base_done);
        chk("sha3_256_perm", 64'(perm_cnt - base_perm), 64'd0);
        chk("sha3_256_queue", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
